sad_best_match: RTL and testbench

- Sequencer and consumer on the result side of the 4x4 SAD processing element.
- Walks every candidate displacement of a full-search window in raster order and drives the PE enable.
- Tags each issued candidate and realigns the tag with the PE's 5-stage pipelined SAD output.
- Keeps the minimum SAD and its motion vector; reports them with a done pulse.
- Sits between the search-window feeder (which consumes cand_dx/cand_dy) and the motion-vector writer.

---
 rtl/fsbm_pkg.sv | 23 ++
 rtl/sad_tag_pipe.sv | 29 ++
 rtl/sad_best_match.sv | 129 ++++++++++++
 tb/tb_sad_best_match.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsbm_pkg.sv
// Shared defaults, FSM state encoding and candidate tag layout for the
// full-search block-matching result sequencer.
package fsbm_pkg;

  localparam int SR_DEF     = 4;
  localparam int PE_LAT_DEF = 5;
  localparam int SUM_W_DEF  = 12;
  localparam int MV_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic signed [MV_W_DEF-1:0] dx;
    logic signed [MV_W_DEF-1:0] dy;
  } tag_t;

endpackage

// File: rtl/sad_tag_pipe.sv
// Fixed-depth delay line of candidate tags; advances only when i_shift is high.
// Async clear empties every stage so a reset drops any in-flight candidates.
module sad_tag_pipe
  import fsbm_pkg::*;
#(
  parameter int  DEPTH = PE_LAT_DEF,
  parameter type T     = tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_shift,
  input  T     i_tag,
  output T     o_tag
);

  T r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_shift) begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/sad_best_match.sv
// Full-search sequencer: issues every displacement in raster order to the SAD PE,
// realigns each candidate with its pipelined SAD and reports the minimum with a done pulse.
module sad_best_match
  import fsbm_pkg::*;
#(
  parameter int SR     = SR_DEF,
  parameter int PE_LAT = PE_LAT_DEF,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int MV_W   = MV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    pe_enable,
  output logic                    cand_valid,
  output logic signed [MV_W-1:0]  cand_dx,
  output logic signed [MV_W-1:0]  cand_dy,
  input  logic        [SUM_W-1:0] sum_in,
  output logic                    busy,
  output logic                    done,
  output logic        [SUM_W-1:0] best_sad,
  output logic signed [MV_W-1:0]  best_dx,
  output logic signed [MV_W-1:0]  best_dy
);

  typedef struct packed {
    logic                   valid;
    logic signed [MV_W-1:0] dx;
    logic signed [MV_W-1:0] dy;
  } cand_tag_t;

  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR);
  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
  localparam int                     CNT_W  = $clog2(PE_LAT + 1);
  localparam logic [CNT_W-1:0]       DRAIN_LAST = CNT_W'(PE_LAT - 1);

  state_t           r_state;
  logic             r_first;
  logic [CNT_W-1:0] r_drain_cnt;

  cand_tag_t w_tag_in;
  cand_tag_t w_tag_out;
  logic      w_shift;
  logic      w_better;

  assign w_shift  = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_tag_in = '{valid: cand_valid, dx: cand_dx, dy: cand_dy};
  // Strict less-than keeps the earliest raster candidate on ties.
  assign w_better = r_first || (sum_in < best_sad);

  sad_tag_pipe #(
    .DEPTH (PE_LAT),
    .T     (cand_tag_t)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (w_shift),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_first     <= 1'b0;
      r_drain_cnt <= '0;
      pe_enable   <= 1'b0;
      cand_valid  <= 1'b0;
      cand_dx     <= '0;
      cand_dy     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_sad    <= '0;
      best_dx     <= '0;
      best_dy     <= '0;
    end else begin
      if (w_tag_out.valid) begin
        if (w_better) begin
          best_sad <= sum_in;
          best_dx  <= w_tag_out.dx;
          best_dy  <= w_tag_out.dy;
        end
        r_first <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ISSUE;
            cand_dx    <= MV_MIN;
            cand_dy    <= MV_MIN;
            r_first    <= 1'b1;
            pe_enable  <= 1'b1;
            cand_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if ((cand_dx == MV_MAX) && (cand_dy == MV_MAX)) begin
            r_state     <= DRAIN;
            cand_valid  <= 1'b0;
            r_drain_cnt <= '0;
          end else if (cand_dx == MV_MAX) begin
            cand_dx <= MV_MIN;
            cand_dy <= cand_dy + MV_W'(1);
          end else begin
            cand_dx <= cand_dx + MV_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state   <= DONE;
            pe_enable <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_best_match.sv
// Bench for sad_best_match: a 5-deep PE model feeds SADs from a per-candidate table,
// and results are checked against a raster-order minimum search over that table.
module tb_sad_best_match;

  localparam int SR     = 4;
  localparam int W      = 2*SR + 1;
  localparam int N      = W*W;
  localparam int PE_LAT = 5;
  localparam int SUM_W  = 12;
  localparam int MV_W   = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    pe_enable;
  logic                    cand_valid;
  logic signed [MV_W-1:0]  cand_dx;
  logic signed [MV_W-1:0]  cand_dy;
  logic        [SUM_W-1:0] sum_in;
  logic                    busy;
  logic                    done;
  logic        [SUM_W-1:0] best_sad;
  logic signed [MV_W-1:0]  best_dx;
  logic signed [MV_W-1:0]  best_dy;

  sad_best_match #(
    .SR(SR), .PE_LAT(PE_LAT), .SUM_W(SUM_W), .MV_W(MV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pe_enable(pe_enable), .cand_valid(cand_valid),
    .cand_dx(cand_dx), .cand_dy(cand_dy), .sum_in(sum_in),
    .busy(busy), .done(done),
    .best_sad(best_sad), .best_dx(best_dx), .best_dy(best_dy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  int sad_tab [N];
  logic [SUM_W-1:0] pe_pipe [PE_LAT];
  bit cap_en = 1'b0;
  int cap_val = 0;

  function automatic int idx(input int x, input int y);
    return (y + SR) * W + (x + SR);
  endfunction

  // PE model: whatever was presented in a cycle with pe_enable appears PE_LAT cycles later.
  always @(negedge clk) begin
    cap_en  = pe_enable;
    cap_val = cand_valid ? sad_tab[idx(int'(cand_dx), int'(cand_dy))]
                         : int'($urandom_range(0, 4095));
  end

  always @(posedge clk) begin
    #1;
    if (cap_en) begin
      for (int i = PE_LAT-1; i > 0; i--) pe_pipe[i] = pe_pipe[i-1];
      pe_pipe[0] = SUM_W'(cap_val);
    end
    sum_in = pe_pipe[PE_LAT-1];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill_const(input int base, input int mx, input int my, input int mval);
    for (int i = 0; i < N; i++) sad_tab[i] = base;
    sad_tab[idx(mx, my)] = mval;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < N; i++) sad_tab[i] = int'($urandom_range(hi, lo));
  endtask

  // Raster-order minimum; a later equal value never displaces an earlier one.
  task automatic ref_best(output int s, output int dx, output int dy);
    bit have;
    have = 1'b0; s = 0; dx = 0; dy = 0;
    for (int y = -SR; y <= SR; y++)
      for (int x = -SR; x <= SR; x++)
        if (!have || sad_tab[idx(x, y)] < s) begin
          have = 1'b1; s = sad_tab[idx(x, y)]; dx = x; dy = y;
        end
  endtask

  // Starts a search (start sampled at edge 0) and observes cycles 1..win at the negedge.
  task automatic run(input int hold, input int repulse, input int rst_at, input bit stop_on_done,
                     input int win, output int done_cyc, output int ndone,
                     output int npe, output int ncv, output int last_busy);
    done_cyc = -1; ndone = 0; npe = 0; ncv = 0; last_busy = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= win; c++) begin
      #1;
      start = (c < hold) || (c == repulse);
      if (c == rst_at) rst_n = 1'b0;
      else if (c == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        chk("first_cand_dx", int'(cand_dx), -SR);
        chk("first_cand_dy", int'(cand_dy), -SR);
      end
      if (c == rst_at) begin
        chk("rst_busy", int'(busy), 0);
        chk("rst_pe_enable", int'(pe_enable), 0);
        chk("rst_cand_valid", int'(cand_valid), 0);
        chk("rst_best_sad", int'(best_sad), 0);
        chk("rst_cand_dx", int'(cand_dx), 0);
      end
      if (pe_enable) npe++;
      if (cand_valid) ncv++;
      last_busy = int'(busy);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        if (stop_on_done) break;
      end
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int base; int mx; int my; int mval;
    int e_sad; int e_dx; int e_dy;
  } vec_t;

  vec_t vt [6];

  task automatic check_result(input string tag, input int dc, input int nd,
                              input int es, input int ex, input int ey);
    chk({tag, "_done_cycle"}, dc, N + PE_LAT + 1);
    chk({tag, "_done_count"}, nd, 1);
    chk({tag, "_best_sad"}, int'(best_sad), es);
    chk({tag, "_best_dx"}, int'(best_dx), ex);
    chk({tag, "_best_dy"}, int'(best_dy), ey);
  endtask

  initial begin
    int dc, nd, npe, ncv, lb, es, ex, ey;
    start = 1'b0;
    rst_n = 1'b0;
    sum_in = '0;
    for (int i = 0; i < PE_LAT; i++) pe_pipe[i] = '0;
    for (int i = 0; i < N; i++) sad_tab[i] = 0;

    vt[0] = '{base: 100,  mx: 0,  my: 0,  mval: 100,  e_sad: 100,  e_dx: -4, e_dy: -4};
    vt[1] = '{base: 500,  mx: 2,  my: -1, mval: 7,    e_sad: 7,    e_dx: 2,  e_dy: -1};
    vt[2] = '{base: 50,   mx: 4,  my: 4,  mval: 0,    e_sad: 0,    e_dx: 4,  e_dy: 4};
    vt[3] = '{base: 4095, mx: -4, my: -4, mval: 4094, e_sad: 4094, e_dx: -4, e_dy: -4};
    vt[4] = '{base: 9,    mx: 0,  my: 0,  mval: 8,    e_sad: 8,    e_dx: 0,  e_dy: 0};
    vt[5] = '{base: 200,  mx: -4, my: 4,  mval: 199,  e_sad: 199,  e_dx: -4, e_dy: 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pe_enable", int'(pe_enable), 0);
    chk("reset_cand_valid", int'(cand_valid), 0);
    chk("reset_cand_dx", int'(cand_dx), 0);
    chk("reset_cand_dy", int'(cand_dy), 0);
    chk("reset_best_sad", int'(best_sad), 0);
    chk("reset_best_dx", int'(best_dx), 0);
    chk("reset_best_dy", int'(best_dy), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill_const(vt[v].base, vt[v].mx, vt[v].my, vt[v].mval);
      run(1, -1, -100, 1'b0, 90, dc, nd, npe, ncv, lb);
      check_result("table", dc, nd, vt[v].e_sad, vt[v].e_dx, vt[v].e_dy);
      chk("table_pe_enable_cycles", npe, N + PE_LAT);
      chk("table_cand_valid_cycles", ncv, N);
      chk("table_idle_after", lb, 0);
    end

    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) fill_rand(0, 4095);
      else fill_rand(0, 7);
      ref_best(es, ex, ey);
      run(1, -1, -100, 1'b0, 90, dc, nd, npe, ncv, lb);
      check_result("random", dc, nd, es, ex, ey);
    end

    // start held three cycles, then re-pulsed in DRAIN: still exactly one search.
    fill_const(vt[1].base, vt[1].mx, vt[1].my, vt[1].mval);
    run(3, N + 3, -100, 1'b0, 100, dc, nd, npe, ncv, lb);
    check_result("held_start", dc, nd, 7, 2, -1);
    chk("held_start_pe_cycles", npe, N + PE_LAT);
    chk("held_start_idle_after", lb, 0);

    // Reset in cycle 40 aborts the search without a done pulse.
    fill_const(vt[2].base, vt[2].mx, vt[2].my, vt[2].mval);
    run(1, -1, 40, 1'b0, 60, dc, nd, npe, ncv, lb);
    chk("abort_done_count", nd, 0);
    chk("abort_pe_cycles", npe, 39);
    chk("abort_cand_valid_cycles", ncv, 39);
    chk("abort_busy_after", lb, 0);
    chk("abort_best_sad", int'(best_sad), 0);
    fill_rand(0, 4095);
    ref_best(es, ex, ey);
    run(1, -1, -100, 1'b0, 90, dc, nd, npe, ncv, lb);
    check_result("after_abort", dc, nd, es, ex, ey);

    // Back-to-back: the second search starts in the cycle after done.
    fill_const(vt[1].base, vt[1].mx, vt[1].my, vt[1].mval);
    run(1, -1, -100, 1'b1, 90, dc, nd, npe, ncv, lb);
    check_result("b2b_first", dc, nd, 7, 2, -1);
    fill_rand(100, 4095);
    ref_best(es, ex, ey);
    run(1, -1, -100, 1'b0, 90, dc, nd, npe, ncv, lb);
    check_result("b2b_second", dc, nd, es, ex, ey);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
